aux_uart_boot_loader: RTL

// - Upstream of the MCU's program memory: receives a program image over the auxiliary UART pin (8N1).
// - Emits word writes into the MCU memory and holds the MCU in reset until the image is complete.
// - Serves boards built with BOOT_FROM_AUX_UART; replaces the fixed memory image at power-up.
//

---
 rtl/aux_boot_pkg.sv | 11 +
 rtl/aux_uart_rx.sv | 90 +++++++++
 rtl/aux_uart_boot_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/aux_boot_pkg.sv
// Shared types and constants for the auxiliary UART boot loader.
package aux_boot_pkg;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef enum logic [2:0] {P_LEN_LO, P_LEN_HI, P_DATA, P_CSUM, P_DONE} proto_state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned LEN_BYTES  = 2;

endpackage

// File: rtl/aux_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, baud counter and sampling FSM.
// Emits a one-cycle byte_valid on a good stop bit, frame_err on a bad one.
module aux_uart_rx
   import aux_boot_pkg::*;
#(
   parameter int unsigned DIV = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int unsigned      CNT_W     = $clog2(DIV + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

   logic [1:0]       sync;
   logic             rx_s;
   logic             rx_prev;
   rx_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   assign rx_s = sync[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync       <= 2'b11;
         rx_prev    <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         sync       <= {sync[0], rx};
         rx_prev    <= rx_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (rx_prev && !rx_s) state <= RX_START;
            end
            RX_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  // A start bit that is high again at mid-bit was a glitch.
                  state   <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_s, shift[7:1]};
                  if (bit_idx == 3'd7) state <= RX_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= RX_IDLE;
                  if (rx_s) begin
                     byte_valid <= 1'b1;
                     byte_data  <= shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/aux_uart_boot_loader.sv
// Loads a program image from the aux UART into MCU memory, holding the MCU in reset until done.
// Optional trailing XOR checksum byte enabled by defining AUX_BOOT_CHECKSUM_EN.
module aux_uart_boot_loader
   import aux_boot_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 50_000_000,
   parameter int unsigned BAUD_RATE     = 115_200,
   parameter int unsigned ADDR_W        = 12,
   parameter int unsigned TIMEOUT_BITS  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mcu_reset_n,
   output logic              busy,
   output logic              error
);

   localparam int unsigned      DIV       = CLK_FREQUENCY / BAUD_RATE;
   localparam int unsigned      TMO_LIMIT = TIMEOUT_BITS * DIV;
   localparam int unsigned      TMO_W     = $clog2(TMO_LIMIT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_LIMIT - 1);
   localparam logic [1:0]       LAST_BYTE = 2'(WORD_BYTES - 1);

   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             frame_err;
   proto_state_t     state;
   logic [15:0]      len;
   logic [15:0]      words;
   logic [1:0]       byte_idx;
   logic [23:0]      word_buf;
   logic [7:0]       csum;
   logic [TMO_W-1:0] tmo;
   logic             tmo_active;
   logic             timeout_hit;

   aux_uart_rx #(
      .DIV (DIV)
   ) u_rx (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   assign tmo_active  = (state == P_LEN_HI) || (state == P_DATA) || (state == P_CSUM);
   // An arriving byte always beats an expiring timeout.
   assign timeout_hit = tmo_active && !byte_valid && (tmo == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= P_LEN_LO;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mcu_reset_n <= 1'b0;
         busy        <= 1'b0;
         error       <= 1'b0;
         len         <= '0;
         words       <= '0;
         byte_idx    <= '0;
         word_buf    <= '0;
         csum        <= '0;
         tmo         <= '0;
      end else begin
         mem_we <= 1'b0;
         if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
         if (tmo_active && !byte_valid) tmo <= tmo + TMO_W'(1);
         else tmo <= '0;

         if (state != P_DONE && (frame_err || timeout_hit)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= P_LEN_LO;
         end else begin
            case (state)
               P_LEN_LO: if (byte_valid) begin
                  len[7:0] <= byte_data;
                  csum     <= byte_data;
                  error    <= 1'b0;
                  state    <= P_LEN_HI;
               end
               P_LEN_HI: if (byte_valid) begin
                  len[15:8] <= byte_data;
                  csum      <= csum ^ byte_data;
                  busy      <= 1'b1;
                  mem_addr  <= '0;
                  words     <= '0;
                  byte_idx  <= '0;
                  if ({byte_data, len[7:0]} != 16'd0) begin
                     state <= P_DATA;
                  end else begin
`ifdef AUX_BOOT_CHECKSUM_EN
                     state <= P_CSUM;
`else
                     state       <= P_DONE;
                     mcu_reset_n <= 1'b1;
                     busy        <= 1'b0;
`endif
                  end
               end
               P_DATA: begin
                  if (byte_valid) begin
                     csum     <= csum ^ byte_data;
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == LAST_BYTE) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {byte_data, word_buf};
                        words     <= words + 16'd1;
                     end else begin
                        word_buf <= {byte_data, word_buf[23:8]};
                     end
                  end else if (mem_we && words == len) begin
`ifdef AUX_BOOT_CHECKSUM_EN
                     state <= P_CSUM;
`else
                     state       <= P_DONE;
                     mcu_reset_n <= 1'b1;
                     busy        <= 1'b0;
`endif
                  end
               end
               P_CSUM: if (byte_valid) begin
                  busy <= 1'b0;
                  if (byte_data == csum) begin
                     state       <= P_DONE;
                     mcu_reset_n <= 1'b1;
                  end else begin
                     error <= 1'b1;
                     state <= P_LEN_LO;
                  end
               end
               P_DONE: ;
               default: state <= P_LEN_LO;
            endcase
         end
      end
   end

endmodule
